// File: rtl/mem_access_ctrl_if.sv
// Bundle of the client command/write/read-return handshakes and the word
// memory pins driven by mem_access_ctrl.
//   cmd_*     : burst command (valid/ready), rw, start address, beats-1
//   wr_*      : write beat stream (valid/ready/data)
//   rd_*      : read beat return (valid/data, no backpressure)
//   done      : one-cycle burst completion pulse
//   mem_*     : memory strobe, read/write select, address, write/read data
// Modports: slave = controller view, master = client + memory view.
interface mem_access_ctrl_if #(
  parameter int AW = 8,
  parameter int DW = 32
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_rw;
  logic [AW-1:0] cmd_addr;
  logic [3:0]    cmd_len;
  logic          wr_valid;
  logic          wr_ready;
  logic [DW-1:0] wr_data;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          done;
  logic          mem_en;
  logic          mem_RW;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  cmd_valid, cmd_rw, cmd_addr, cmd_len, wr_valid, wr_data, mem_rdata,
    output cmd_ready, wr_ready, rd_valid, rd_data, done,
           mem_en, mem_RW, mem_addr, mem_wdata
  );

  modport master (
    output cmd_valid, cmd_rw, cmd_addr, cmd_len, wr_valid, wr_data, mem_rdata,
    input  cmd_ready, wr_ready, rd_valid, rd_data, done,
           mem_en, mem_RW, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Burst memory access controller: takes read/write burst commands and drives
// the word memory one beat per cycle, returning read data after RD_LAT cycles.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : mem_access_ctrl_if.slave (command, write stream, read return,
//          done pulse and registered memory pins)
// Parameters: AW address width (wraps), DW data width, RD_LAT 1..4.
module mem_access_ctrl #(
  parameter int AW     = 8,
  parameter int DW     = 32,
  parameter int RD_LAT = 1
) (
  input  logic           clk,
  input  logic           rst,
  mem_access_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_READ, S_DRAIN, S_FIN
  } state_t;

  state_t        state_q;
  logic [AW-1:0] cur_q;
  logic [4:0]    rem_q;
  logic          mem_en_q;
  logic          mem_rw_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;
  logic          done_q;

  // vld_pipe_q[0] is high in the cycle a read strobe sits on the pins;
  // vld_pipe_q[RD_LAT] marks the cycle mem_rdata belongs to that strobe.
  logic [RD_LAT:0] vld_pipe_q;
  logic [RD_LAT:0] vld_pipe_d;
  logic            rd_valid_q;
  logic [DW-1:0]   rd_data_q;
  logic            last_rd;

  // Read strobes are contiguous, so the beat reaching the end of the pipe
  // with nothing behind it is the last one of the burst.
  assign last_rd    = vld_pipe_q[RD_LAT] & ~(|vld_pipe_q[RD_LAT-1:0]);
  assign vld_pipe_d = {vld_pipe_q[RD_LAT-1:0], (state_q == S_READ)};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cur_q       <= '0;
      rem_q       <= '0;
      mem_en_q    <= 1'b0;
      mem_rw_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      done_q      <= 1'b0;
    end else begin
      mem_en_q <= 1'b0;
      done_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            cur_q   <= bus.cmd_addr;
            rem_q   <= {1'b0, bus.cmd_len} + 5'd1;
            state_q <= bus.cmd_rw ? S_WRITE : S_READ;
          end
        end
        S_WRITE: begin
          if (bus.wr_valid) begin
            mem_en_q    <= 1'b1;
            mem_rw_q    <= 1'b1;
            mem_addr_q  <= cur_q;
            mem_wdata_q <= bus.wr_data;
            cur_q       <= cur_q + AW'(1);
            rem_q       <= rem_q - 5'd1;
            // done lines up with the last strobe, which shows in FIN
            if (rem_q == 5'd1) begin
              state_q <= S_FIN;
              done_q  <= 1'b1;
            end
          end
        end
        S_READ: begin
          mem_en_q   <= 1'b1;
          mem_rw_q   <= 1'b0;
          mem_addr_q <= cur_q;
          cur_q      <= cur_q + AW'(1);
          rem_q      <= rem_q - 5'd1;
          if (rem_q == 5'd1) state_q <= S_DRAIN;
        end
        S_DRAIN: begin
          // done is registered one cycle ahead so it pairs with the last
          // rd_valid; leave once it is on the output.
          if (done_q) state_q <= S_IDLE;
          else        done_q  <= last_rd;
        end
        S_FIN:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_pipe_q <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      rd_valid_q <= vld_pipe_q[RD_LAT];
      if (vld_pipe_q[RD_LAT]) rd_data_q <= bus.mem_rdata;
    end
  end

  assign bus.cmd_ready = (state_q == S_IDLE);
  assign bus.wr_ready  = (state_q == S_WRITE);
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.done      = done_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_RW    = mem_rw_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule
